// File: rtl/ether_tx.sv
// RMII transmitter: preamble/SFD, then payload dibits with a ready strobe,
// then the FCS and the inter-frame gap. The FCS/CRC path exists only when
// ETHER_TX_FCS_EN is defined; without it the frame ends after the payload.
module ether_tx (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       trigger_in,
  input  logic [1:0] data_in,
  input  logic       last_dibit_in,
  output logic       ready_out,
  output logic       data_ready_out,
  output logic       eth_txen,
  output logic [1:0] eth_txd
);

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    DATA,
    FCS,
    IFG
  } state_e;

  state_e     state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic       ready_q, ready_d;
  logic       dready_q, dready_d;
  logic       txen_q, txen_d;
  logic [1:0] txd_q, txd_d;

`ifdef ETHER_TX_FCS_EN
  logic [31:0] crc_q, crc_d;

  // Reflected CRC-32, two bits per call, d[0] first.
  function automatic logic [31:0] crc_dibit(input logic [31:0] c, input logic [1:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 2; i++) begin
      r = (r >> 1) ^ (((r[0] ^ d[i]) == 1'b1) ? 32'hEDB88320 : 32'h0000_0000);
    end
    return r;
  endfunction
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ready_d  = 1'b0;
    dready_d = 1'b0;
    txen_d   = 1'b0;
    txd_d    = 2'b00;
`ifdef ETHER_TX_FCS_EN
    crc_d    = crc_q;
`endif
    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (trigger_in) begin
          state_d = PREAMBLE;
          cnt_d   = 6'd0;
          ready_d = 1'b0;
          txen_d  = 1'b1;
          txd_d   = 2'b01;
`ifdef ETHER_TX_FCS_EN
          crc_d   = 32'hFFFF_FFFF;
`endif
        end
      end
      PREAMBLE: begin
        txen_d = 1'b1;
        cnt_d  = cnt_q + 6'd1;
        if (cnt_q == 6'd30) begin
          // The SFD's closing 11 dibit goes out on the same edge that enters DATA.
          txd_d    = 2'b11;
          dready_d = 1'b1;
          state_d  = DATA;
          cnt_d    = 6'd0;
        end else begin
          txd_d = 2'b01;
        end
      end
      DATA: begin
        txen_d = 1'b1;
        txd_d  = data_in;
`ifdef ETHER_TX_FCS_EN
        crc_d  = crc_dibit(crc_q, data_in);
`endif
        if (last_dibit_in) begin
`ifdef ETHER_TX_FCS_EN
          state_d = FCS;
`else
          state_d = IFG;
`endif
          cnt_d = 6'd0;
        end else begin
          dready_d = 1'b1;
        end
      end
`ifdef ETHER_TX_FCS_EN
      FCS: begin
        // The CRC register is shifted out LSB-first, inverted.
        txen_d = 1'b1;
        txd_d  = ~crc_q[1:0];
        crc_d  = {2'b00, crc_q[31:2]};
        cnt_d  = cnt_q + 6'd1;
        if (cnt_q == 6'd15) begin
          state_d = IFG;
          cnt_d   = 6'd0;
        end
      end
`endif
      IFG: begin
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd48) begin
          state_d = IDLE;
          ready_d = 1'b1;
          cnt_d   = 6'd0;
        end
      end
      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
        cnt_d   = 6'd0;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q  <= IDLE;
      cnt_q    <= 6'd0;
      ready_q  <= 1'b1;
      dready_q <= 1'b0;
      txen_q   <= 1'b0;
      txd_q    <= 2'b00;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ready_q  <= ready_d;
      dready_q <= dready_d;
      txen_q   <= txen_d;
      txd_q    <= txd_d;
    end
  end

`ifdef ETHER_TX_FCS_EN
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      crc_q <= 32'hFFFF_FFFF;
    end else begin
      crc_q <= crc_d;
    end
  end
`endif

  assign ready_out      = ready_q;
  assign data_ready_out = dready_q;
  assign eth_txen       = txen_q;
  assign eth_txd        = txd_q;

endmodule

// File: tb/tb_ether_tx.sv
// Scoreboard bench for ether_tx: a byte-level frame model feeds expected wire
// dibits, frame spans and gap lengths to a monitor sampling on the falling edge.
module tb_ether_tx;

  logic       clk_in = 1'b0;
  logic       rst_in = 1'b0;
  logic       trigger_in = 1'b0;
  logic [1:0] data_in = 2'b00;
  logic       last_dibit_in = 1'b0;
  logic       ready_out;
  logic       data_ready_out;
  logic       eth_txen;
  logic [1:0] eth_txd;

  int testsRun = 0;
  int testsFailed = 0;

`ifdef ETHER_TX_FCS_EN
  localparam int FcsDibits = 16;
`else
  localparam int FcsDibits = 0;
`endif

  logic [1:0] expDibits[$];
  int         expSpan[$];
  int         expPayload[$];

  ether_tx dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .trigger_in    (trigger_in),
    .data_in       (data_in),
    .last_dibit_in (last_dibit_in),
    .ready_out     (ready_out),
    .data_ready_out(data_ready_out),
    .eth_txen      (eth_txen),
    .eth_txd       (eth_txd)
  );

  always #10 clk_in = ~clk_in;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic abortTimeout(input string name);
    testsRun++;
    testsFailed++;
    $display("[TB] FAIL %s: timed out waiting on DUT", name);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  endtask

  // Standard bitwise CRC-32 over bytes, LSB first; returns the transmitted FCS value.
  function automatic logic [31:0] fcsModel(input logic [7:0] p[$]);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    foreach (p[i]) begin
      for (int b = 0; b < 8; b++) begin
        if ((c[0] ^ p[i][b]) == 1'b1) c = (c >> 1) ^ 32'hEDB88320;
        else c = c >> 1;
      end
    end
    return ~c;
  endfunction

  task automatic pushByte(input logic [7:0] b);
    for (int k = 0; k < 4; k++) expDibits.push_back(b[2*k +: 2]);
  endtask

  task automatic pushExpected(input logic [7:0] p[$], input logic [31:0] fcs);
    logic [31:0] f;
    f = fcs;
    for (int i = 0; i < 7; i++) pushByte(8'h55);
    pushByte(8'hD5);
    foreach (p[i]) pushByte(p[i]);
    if (FcsDibits != 0) begin
      for (int j = 0; j < 4; j++) pushByte(f[8*j +: 8]);
    end
    expSpan.push_back(32 + 4 * p.size() + FcsDibits);
    expPayload.push_back(4 * p.size());
  endtask

  task automatic waitReady();
    int t = 0;
    while (!ready_out && t < 200) begin
      @(negedge clk_in);
      t++;
    end
    if (!ready_out) abortTimeout("ready wait");
  endtask

  task automatic waitDataReady();
    int t = 0;
    @(negedge clk_in);
    while (!data_ready_out && t < 64) begin
      @(negedge clk_in);
      t++;
    end
    if (!data_ready_out) abortTimeout("data_ready wait");
  endtask

  task automatic startFrame();
    waitReady();
    trigger_in = 1'b1;
    @(negedge clk_in);
    trigger_in = 1'b0;
    checkOutput("start txen", {31'd0, eth_txen}, 32'd1);
    checkOutput("start ready", {31'd0, ready_out}, 32'd0);
  endtask

  task automatic applyStimulus(input logic [7:0] p[$], input logic [31:0] fcs, input bit pulseTrig);
    int nd;
    int pulseAt;
    logic [7:0] b;
    nd = 4 * p.size();
    pulseAt = $urandom_range(nd - 1, 0);
    pushExpected(p, fcs);
    startFrame();
    for (int i = 0; i < nd; i++) begin
      waitDataReady();
      b = p[i / 4];
      data_in = b[2*(i % 4) +: 2];
      last_dibit_in = (i == nd - 1);
      trigger_in = pulseTrig && (i == pulseAt);
    end
    @(negedge clk_in);
    data_in = 2'b00;
    last_dibit_in = 1'b0;
    trigger_in = 1'b0;
    checkOutput("data_ready after last", {31'd0, data_ready_out}, 32'd0);
    if (pulseTrig) begin
      repeat (20) @(negedge clk_in);
      trigger_in = 1'b1;
      @(negedge clk_in);
      trigger_in = 1'b0;
    end
  endtask

  // Monitor: compares every TX_EN-high dibit and the frame/gap geometry.
  int spanCnt = 0;
  int dreadyCnt = 0;
  int gapCnt = 0;
  bit prevTxen = 1'b0;
  bit inGap = 1'b0;
  logic [1:0] expD;
  int expN;

  always @(negedge clk_in) begin
    if (!rst_in) begin
      spanCnt = 0;
      dreadyCnt = 0;
      prevTxen = 1'b0;
      inGap = 1'b0;
    end else begin
      if (eth_txen) begin
        if (expDibits.size() == 0) begin
          checkOutput("unexpected txen", 32'd1, 32'd0);
        end else begin
          expD = expDibits.pop_front();
          checkOutput("txd", {30'd0, eth_txd}, {30'd0, expD});
        end
        if (spanCnt == 31) checkOutput("data_ready at SFD", {31'd0, data_ready_out}, 32'd1);
        if (data_ready_out) dreadyCnt++;
        spanCnt++;
      end else if (prevTxen) begin
        expN = (expSpan.size() != 0) ? expSpan.pop_front() : -1;
        checkOutput("txen span", spanCnt, expN);
        expN = (expPayload.size() != 0) ? expPayload.pop_front() : -1;
        checkOutput("data_ready cycles", dreadyCnt, expN);
        checkOutput("txd after txen", {30'd0, eth_txd}, 32'd0);
        spanCnt = 0;
        dreadyCnt = 0;
        inGap = 1'b1;
        gapCnt = 0;
      end
      if (inGap) begin
        if (ready_out) begin
          checkOutput("ifg length", gapCnt, 48);
          inGap = 1'b0;
        end else begin
          gapCnt++;
        end
      end
      prevTxen = eth_txen;
    end
  end

  initial begin
    logic [7:0] p[$];
    logic [7:0] b;
    int t;

    repeat (3) @(negedge clk_in);
    checkOutput("reset ready", {31'd0, ready_out}, 32'd1);
    checkOutput("reset txen", {31'd0, eth_txen}, 32'd0);
    rst_in = 1'b1;
    repeat (10) @(negedge clk_in);
    checkOutput("idle ready", {31'd0, ready_out}, 32'd1);
    checkOutput("idle txen", {31'd0, eth_txen}, 32'd0);
    checkOutput("idle txd", {30'd0, eth_txd}, 32'd0);
    checkOutput("idle data_ready", {31'd0, data_ready_out}, 32'd0);

    p.delete();
    for (int i = 0; i < 10; i++) p.push_back(8'h00);
    applyStimulus(p, fcsModel(p), 1'b0);

    p.delete();
    for (int i = 0; i < 4; i++) p.push_back(8'h00);
    applyStimulus(p, 32'h2144DF1C, 1'b1);

    // Truncate a frame mid-payload with an asynchronous reset.
    p.delete();
    for (int i = 0; i < 8; i++) p.push_back(8'($urandom_range(255, 0)));
    pushExpected(p, fcsModel(p));
    startFrame();
    for (int i = 0; i < 10; i++) begin
      waitDataReady();
      b = p[i / 4];
      data_in = b[2*(i % 4) +: 2];
    end
    @(posedge clk_in);
    #2;
    rst_in = 1'b0;
    #1;
    checkOutput("abort ready", {31'd0, ready_out}, 32'd1);
    checkOutput("abort txen", {31'd0, eth_txen}, 32'd0);
    checkOutput("abort txd", {30'd0, eth_txd}, 32'd0);
    checkOutput("abort data_ready", {31'd0, data_ready_out}, 32'd0);
    expDibits.delete();
    expSpan.delete();
    expPayload.delete();
    data_in = 2'b00;
    repeat (2) @(negedge clk_in);
    rst_in = 1'b1;
    @(negedge clk_in);

    p.delete();
    for (int i = 0; i < 9; i++) p.push_back(8'h31 + 8'(i));
    applyStimulus(p, 32'hCBF43926, 1'b0);

    for (int f = 0; f < 6; f++) begin
      p.delete();
      for (int i = 0; i < int'($urandom_range(16, 2)); i++) p.push_back(8'($urandom_range(255, 0)));
      applyStimulus(p, fcsModel(p), f[0]);
    end

    t = 0;
    while ((expSpan.size() != 0 || inGap || eth_txen) && t < 400) begin
      @(negedge clk_in);
      t++;
    end
    checkOutput("scoreboard drained", expDibits.size() + expSpan.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
